// File: rtl/mult_div_seq_pkg.sv
// Shared encodings for the sequential signed MULT/DIV unit.
package mult_div_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MULT = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_seq_cond_negate.sv
// Two's-complement negate when neg_i is set; otherwise pass through.
module cond_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in_i,
  input  logic         neg_i,
  output logic [N-1:0] out_o
);

  assign out_o = neg_i ? -in_i : in_i;

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed multiply / restoring divide on magnitudes, with a final
// sign-fix cycle that writes the HI/LO result registers.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2:0]         state_q;
  logic [CW-1:0]      count_q;
  logic               op_q;
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     multSum;
  logic [WIDTH-1:0]   remShift;
  logic [WIDTH:0]     divTrial;
  logic               borrow;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  cond_negate #(.N(WIDTH)) uAbsA (.in_i(op_a), .neg_i(op_a[WIDTH-1]), .out_o(absA));
  cond_negate #(.N(WIDTH)) uAbsB (.in_i(op_b), .neg_i(op_b[WIDTH-1]), .out_o(absB));

  cond_negate #(.N(2*WIDTH)) uProd (.in_i(acc_q), .neg_i(sa_q ^ sb_q), .out_o(prodFix));
  cond_negate #(.N(WIDTH)) uQuo (.in_i(acc_q[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .out_o(quoFix));
  cond_negate #(.N(WIDTH)) uRem (.in_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .out_o(remFix));

  // acc_q holds {partial, multiplier} for MULT and {remainder, quotient} for DIV
  always_comb begin
    addend   = acc_q[0] ? mcand_q : '0;
    multSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    remShift = acc_q[2*WIDTH-2:WIDTH-1];
    divTrial = {1'b0, remShift} - {1'b0, mcand_q};
    borrow   = divTrial[WIDTH];
    acc_d    = acc_q;
    if (op_q == OP_DIV) begin
      acc_d = {(borrow ? remShift : divTrial[WIDTH-1:0]), acc_q[WIDTH-2:0], ~borrow};
    end else begin
      acc_d = {multSum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      op_q       <= OP_MULT;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_mult || start_div) begin
            sa_q    <= op_a[WIDTH-1];
            sb_q    <= op_b[WIDTH-1];
            count_q <= '0;
          end
          if (start_mult) begin
            state_q <= MULT;
            op_q    <= OP_MULT;
            mcand_q <= absA;
            acc_q   <= {{WIDTH{1'b0}}, absB};
            busy_q  <= 1'b1;
          end else if (start_div && (op_b != '0)) begin
            state_q <= DIV;
            op_q    <= OP_DIV;
            mcand_q <= absB;
            acc_q   <= {{WIDTH{1'b0}}, absA};
            busy_q  <= 1'b1;
          end else if (start_div) begin
            // Divide by zero skips the datapath and leaves hi/lo untouched
            state_q    <= DONE;
            done_q     <= 1'b1;
            div_zero_q <= 1'b1;
          end
        end
        MULT, DIV: begin
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (op_q == OP_MULT) begin
            {hi_q, lo_q} <= prodFix;
          end else begin
            hi_q <= remFix;
            lo_q <= quoFix;
          end
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          div_zero_q <= 1'b0;
          state_q    <= DONE;
        end
        DONE: begin
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed corner cases plus random
// operations checked against a plain signed-arithmetic reference.
module tb_mult_div_seq;

  logic        clock;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int testsRun    = 0;
  int testsFailed = 0;

  logic busyFirst;
  logic sawBusy;

  mult_div_seq #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: 64-bit signed arithmetic, truncating division, remainder takes dividend sign
  function automatic void model(input bit isMult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] expHi, output logic [31:0] expLo);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (isMult) begin
      r = sa * sb;
      expHi = r[63:32];
      expLo = r[31:0];
    end else begin
      r = sa / sb;
      expLo = r[31:0];
      r = sa % sb;
      expHi = r[31:0];
    end
  endfunction

  // Issues one start and waits for done; edges = 1 means done in the cycle after the start edge
  task automatic run_op(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                        output int edges);
    @(negedge clock);
    start_mult = sm;
    start_div  = sd;
    op_a = a;
    op_b = b;
    @(posedge clock);
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    edges = -1;
    busyFirst = busy;
    sawBusy = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        edges = n;
        break;
      end
      sawBusy = sawBusy | busy;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_mult = 1'b0;
    start_div = 1'b0;
    op_a = 32'h1234_5678;
    op_b = 32'h9abc_def0;
    repeat (3) @(negedge clock);
    testsRun += 4;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (div_zero !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_divzero: got %b expected 0", div_zero); end
    if ({hi, lo} !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult_directed();
    logic [31:0] aT [2] = '{32'd7, 32'h8000_0000};
    logic [31:0] bT [2] = '{32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] hT [2] = '{32'hFFFF_FFFF, 32'h4000_0000};
    logic [31:0] lT [2] = '{32'hFFFF_FFEB, 32'h0000_0000};
    int edges;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, 1'b0, aT[i], bT[i], edges);
      testsRun += 5;
      if (edges !== 34) begin testsFailed++; $display("[TB] FAIL mult_latency[%0d]: got %0d expected 34", i, edges); end
      if (busyFirst !== 1'b1) begin testsFailed++; $display("[TB] FAIL mult_busy[%0d]: got %b expected 1", i, busyFirst); end
      if (hi !== hT[i]) begin testsFailed++; $display("[TB] FAIL mult_hi[%0d]: got %h expected %h", i, hi, hT[i]); end
      if (lo !== lT[i]) begin testsFailed++; $display("[TB] FAIL mult_lo[%0d]: got %h expected %h", i, lo, lT[i]); end
      if (div_zero !== 1'b0) begin testsFailed++; $display("[TB] FAIL mult_divzero[%0d]: got %b expected 0", i, div_zero); end
    end
  endtask

  task automatic test_div_directed();
    logic [31:0] aT [3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bT [3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] hT [3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
    logic [31:0] lT [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    int edges;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 1'b1, aT[i], bT[i], edges);
      testsRun += 4;
      if (edges !== 34) begin testsFailed++; $display("[TB] FAIL div_latency[%0d]: got %0d expected 34", i, edges); end
      if (hi !== hT[i]) begin testsFailed++; $display("[TB] FAIL div_hi[%0d]: got %h expected %h", i, hi, hT[i]); end
      if (lo !== lT[i]) begin testsFailed++; $display("[TB] FAIL div_lo[%0d]: got %h expected %h", i, lo, lT[i]); end
      if (div_zero !== 1'b0) begin testsFailed++; $display("[TB] FAIL div_divzero[%0d]: got %b expected 0", i, div_zero); end
    end
  endtask

  task automatic test_div_zero();
    int edges;
    run_op(1'b1, 1'b0, 32'd3, 32'd5, edges);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, edges);
    testsRun += 5;
    if (edges !== 1) begin testsFailed++; $display("[TB] FAIL dz_latency: got %0d expected 1", edges); end
    if (div_zero !== 1'b1) begin testsFailed++; $display("[TB] FAIL dz_flag: got %b expected 1", div_zero); end
    if ((busyFirst | busy) !== 1'b0) begin testsFailed++; $display("[TB] FAIL dz_busy: got %b expected 0", busyFirst | busy); end
    if (hi !== 32'd0) begin testsFailed++; $display("[TB] FAIL dz_hi: got %h expected 00000000", hi); end
    if (lo !== 32'd15) begin testsFailed++; $display("[TB] FAIL dz_lo: got %h expected 0000000f", lo); end
    @(negedge clock);
    testsRun += 2;
    if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL dz_done_pulse: got %b expected 0", done); end
    if (div_zero !== 1'b0) begin testsFailed++; $display("[TB] FAIL dz_flag_clear: got %b expected 0", div_zero); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] eh;
    logic [31:0] el;
    int edges;
    bit ghost;
    @(negedge clock);
    start_div = 1'b1;
    op_a = 32'd1000;
    op_b = 32'hFFFF_FFF9;
    @(posedge clock);
    @(negedge clock);
    start_div = 1'b0;
    edges = -1;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        edges = n;
        break;
      end
      start_mult = (n == 10);
      op_a = 32'd3;
      op_b = 32'd3;
      @(negedge clock);
    end
    start_mult = 1'b0;
    model(1'b0, 32'd1000, 32'hFFFF_FFF9, eh, el);
    testsRun += 3;
    if (edges !== 34) begin testsFailed++; $display("[TB] FAIL ign_latency: got %0d expected 34", edges); end
    if (hi !== eh) begin testsFailed++; $display("[TB] FAIL ign_hi: got %h expected %h", hi, eh); end
    if (lo !== el) begin testsFailed++; $display("[TB] FAIL ign_lo: got %h expected %h", lo, el); end

    // A start raised during the DONE cycle must also be dropped
    start_mult = 1'b1;
    op_a = 32'd2;
    op_b = 32'd2;
    @(negedge clock);
    start_mult = 1'b0;
    ghost = 1'b0;
    for (int n = 0; n < 40; n++) begin
      ghost = ghost | done | busy;
      @(negedge clock);
    end
    testsRun += 1;
    if (ghost !== 1'b0) begin testsFailed++; $display("[TB] FAIL ign_done_cycle: got %b expected 0", ghost); end

    run_op(1'b1, 1'b1, 32'hFFFF_FFF6, 32'd9, edges);
    model(1'b1, 32'hFFFF_FFF6, 32'd9, eh, el);
    testsRun += 3;
    if (edges !== 34) begin testsFailed++; $display("[TB] FAIL both_latency: got %0d expected 34", edges); end
    if (hi !== eh) begin testsFailed++; $display("[TB] FAIL both_hi: got %h expected %h", hi, eh); end
    if (lo !== el) begin testsFailed++; $display("[TB] FAIL both_lo: got %h expected %h", lo, el); end
  endtask

  task automatic test_reset_mid_op();
    bit sawDone;
    int edges;
    @(negedge clock);
    start_mult = 1'b1;
    op_a = 32'd12345;
    op_b = 32'hFFFF_FD5A;
    @(posedge clock);
    @(negedge clock);
    start_mult = 1'b0;
    sawDone = 1'b0;
    for (int n = 1; n < 16; n++) begin
      sawDone = sawDone | done;
      @(negedge clock);
    end
    reset = 1'b0;
    #1;
    testsRun += 3;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
    if ({hi, lo} !== 64'h0) begin testsFailed++; $display("[TB] FAIL rmid_hilo: got %h expected 0", {hi, lo}); end
    if ((done | div_zero) !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_flags: got %b expected 0", done | div_zero); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 40; n++) begin
      sawDone = sawDone | done | busy;
      @(negedge clock);
    end
    testsRun += 1;
    if (sawDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_no_done: got %b expected 0", sawDone); end
    run_op(1'b0, 1'b1, 32'd100, 32'd7, edges);
    testsRun += 3;
    if (edges !== 34) begin testsFailed++; $display("[TB] FAIL rmid_latency: got %0d expected 34", edges); end
    if (lo !== 32'd14) begin testsFailed++; $display("[TB] FAIL rmid_lo: got %h expected 0000000e", lo); end
    if (hi !== 32'd2) begin testsFailed++; $display("[TB] FAIL rmid_hi: got %h expected 00000002", hi); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1;
      3: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    bit isMult;
    int edges;
    for (int i = 0; i < 30; i++) begin
      isMult = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      if (!isMult && b == 32'd0) b = 32'd3;
      model(isMult, a, b, eh, el);
      run_op(isMult, !isMult, a, b, edges);
      testsRun += 4;
      if (edges !== 34) begin testsFailed++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected 34", i, edges); end
      if (hi !== eh) begin testsFailed++; $display("[TB] FAIL rnd_hi[%0d] m=%0d a=%h b=%h: got %h expected %h", i, isMult, a, b, hi, eh); end
      if (lo !== el) begin testsFailed++; $display("[TB] FAIL rnd_lo[%0d] m=%0d a=%h b=%h: got %h expected %h", i, isMult, a, b, lo, el); end
      if (div_zero !== 1'b0) begin testsFailed++; $display("[TB] FAIL rnd_divzero[%0d]: got %b expected 0", i, div_zero); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh;
    logic [31:0] el;
    int edges;
    bit mT [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] aT [3] = '{32'hFFFF_8000, 32'h7FFF_FFFF, 32'h0001_0001};
    logic [31:0] bT [3] = '{32'h0000_7FFF, 32'hFFFF_FFF0, 32'hFFFF_0001};
    for (int i = 0; i < 3; i++) begin
      model(mT[i], aT[i], bT[i], eh, el);
      run_op(mT[i], !mT[i], aT[i], bT[i], edges);
      testsRun += 3;
      if (edges !== 34) begin testsFailed++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 34", i, edges); end
      if (hi !== eh) begin testsFailed++; $display("[TB] FAIL b2b_hi[%0d]: got %h expected %h", i, hi, eh); end
      if (lo !== el) begin testsFailed++; $display("[TB] FAIL b2b_lo[%0d]: got %h expected %h", i, lo, el); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
